// File: rtl/tag_pack_fifo_if.sv
// Word-in / entry-out bus of tag_pack_fifo. The slave modport is the FIFO's own view;
// the master modport is the producer/consumer side.
interface tag_pack_fifo_if #(
    parameter int WORD_W = 64,
    parameter int WORDS  = 2,
    parameter int DEPTH  = 4
);
    localparam int ENTRY_W = WORD_W * WORDS;
    localparam int CW      = $clog2(DEPTH + 1);

    logic                clear_i;
    logic [WORD_W-1:0]   word_i;
    logic                word_valid_i;
    logic                word_ready_o;
    logic [ENTRY_W-1:0]  data_o;
    logic                valid_o;
    logic                ready_i;
    logic [CW-1:0]       count_o;
    logic                full_o;
    logic                empty_o;

    modport slave (
        input  clear_i, word_i, word_valid_i, ready_i,
        output word_ready_o, data_o, valid_o, count_o, full_o, empty_o
    );

    modport master (
        output clear_i, word_i, word_valid_i, ready_i,
        input  word_ready_o, data_o, valid_o, count_o, full_o, empty_o
    );
endinterface

// File: rtl/tag_pack_fifo.sv
// Packs WORDS consecutive datapath words (first word in the MSBs) into one entry and
// queues the entries in a DEPTH-deep first-word-fall-through FIFO.
module tag_pack_fifo #(
    parameter int WORD_W = 64,
    parameter int WORDS  = 2,
    parameter int DEPTH  = 4
) (
    input  logic           clock_i,
    input  logic           resetb_i,
    tag_pack_fifo_if.slave bus
);
    localparam int ENTRY_W = WORD_W * WORDS;
    localparam int CW      = $clog2(DEPTH + 1);
    localparam int AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int WCW     = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [WCW-1:0] LAST = WCW'(WORDS - 1);

    generate
        if (WORD_W < 1 || WORDS < 1 || DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_param
            $error("tag_pack_fifo: WORD_W/WORDS must be >=1 and DEPTH a power of two >=2");
        end
    endgenerate

    logic [DEPTH-1:0][ENTRY_W-1:0]  mem;
    logic [WORDS-1:0][WORD_W-1:0]   slots;
    logic [WORDS-1:0][WORD_W-1:0]   asm_entry;
    logic [WCW-1:0]                 wcnt;
    logic [WCW-1:0]                 slot_idx;
    logic [AW-1:0]                  wptr;
    logic [AW-1:0]                  rptr;
    logic [CW-1:0]                  count;
    logic                           is_last;
    logic                           full;
    logic                           word_acc;
    logic                           push;
    logic                           pop;

    assign is_last  = (wcnt == LAST);
    assign full     = (count == CW'(DEPTH));
    // Only the completing word can be blocked; readiness never looks at ready_i.
    assign bus.word_ready_o = !(is_last && full);
    assign word_acc = bus.word_valid_i && bus.word_ready_o;
    assign push     = word_acc && is_last;
    assign pop      = bus.valid_o && bus.ready_i;
    assign slot_idx = LAST - wcnt;

    always_comb begin
        asm_entry    = slots;
        asm_entry[0] = bus.word_i;
    end

    assign bus.data_o  = mem[rptr];
    assign bus.valid_o = (count != '0);
    assign bus.empty_o = (count == '0);
    assign bus.full_o  = full;
    assign bus.count_o = count;

    always_ff @(posedge clock_i or negedge resetb_i) begin
        if (!resetb_i) begin
            mem   <= '0;
            slots <= '0;
            wcnt  <= '0;
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else if (bus.clear_i) begin
            // Stored entries stay in place; only the bookkeeping is flushed.
            wcnt  <= '0;
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (word_acc) begin
                if (is_last) begin
                    mem[wptr] <= asm_entry;
                    wptr      <= wptr + 1'b1;
                    wcnt      <= '0;
                end else begin
                    slots[slot_idx] <= bus.word_i;
                    wcnt            <= wcnt + 1'b1;
                end
            end
            if (pop)
                rptr <= rptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule
